// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, nop encoding and the fetch FSM encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    function automatic word_t next_pc(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: bubble beats load, load beats hold.
module if_id_latch
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  nrst,
    input  logic  load,
    input  logic  bubble,
    input  word_t instr,
    input  word_t npc,
    input  word_t pc,
    output word_t instr_out,
    output word_t npc_out,
    output word_t pc_out,
    output logic  valid_out
);

    always_ff @(posedge clk) begin
        if (!nrst || bubble) begin
            instr_out <= NOP_INSTR;
            npc_out   <= '0;
            pc_out    <= '0;
            valid_out <= 1'b0;
        end else if (load) begin
            instr_out <= instr;
            npc_out   <= npc;
            pc_out    <= pc;
            valid_out <= 1'b1;
        end
    end

endmodule

// File: rtl/stage_if.sv
// Instruction fetch stage: PC, redirect/drain FSM and the IF/ID register.
module stage_if
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h00000000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  stall,
    input  logic  flush,
    input  logic  redirect_en,
    input  word_t redirect_pc,
    input  logic  halt_in,
    output word_t imemload_out,
    output word_t npc_out,
    output word_t pc_out,
    output logic  valid_out
);

    fetch_state_t state, state_next;
    word_t        pc, pc_next;
    word_t        tgt, tgt_next;
    word_t        npc;
    logic         load, bubble;

    assign npc      = next_pc(pc);
    assign imemREN  = (state != HALT);
    assign imemaddr = pc;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        tgt_next   = tgt;
        load       = 1'b0;
        bubble     = 1'b0;
        case (state)
            FETCH: begin
                if (halt_in) begin
                    state_next = HALT;
                    bubble     = 1'b1;
                end else if (redirect_en && ihit) begin
                    pc_next = redirect_pc;
                    bubble  = 1'b1;
                end else if (redirect_en) begin
                    // Hold pc so the outstanding miss completes on its own address.
                    tgt_next   = redirect_pc;
                    state_next = DRAIN;
                    bubble     = 1'b1;
                end else if (stall) begin
                    bubble = 1'b0;
                end else if (ihit) begin
                    load    = 1'b1;
                    pc_next = npc;
                end else begin
                    bubble = 1'b1;
                end
            end
            DRAIN: begin
                bubble = 1'b1;
                if (redirect_en) begin
                    tgt_next = redirect_pc;
                end
                if (halt_in) begin
                    state_next = HALT;
                end else if (ihit) begin
                    pc_next    = redirect_en ? redirect_pc : tgt;
                    state_next = FETCH;
                end
            end
            HALT: begin
                bubble = 1'b1;
            end
            default: begin
                state_next = FETCH;
                bubble     = 1'b1;
            end
        endcase
        if (flush) begin
            bubble = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= FETCH;
            pc    <= PC_INIT;
            tgt   <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            tgt   <= tgt_next;
        end
    end

    if_id_latch u_if_id_latch (
        .clk       (CLK),
        .nrst      (nRST),
        .load      (load),
        .bubble    (bubble),
        .instr     (imemload),
        .npc       (npc),
        .pc        (pc),
        .instr_out (imemload_out),
        .npc_out   (npc_out),
        .pc_out    (pc_out),
        .valid_out (valid_out)
    );

endmodule
